// File: rtl/mips_alu.sv
// mips_alu: EX-stage 32-bit integer ALU for the MIPS-style pipeline.
// Operand/shift-amount muxing, 14 operations, and a one-cycle result
// register (result/zero/overflow) feeding the EX/MEM boundary.

// Barrel shifter for the three shift flavours; all three are computed
// in parallel and the ALU picks one by aluop.
module mips_alu_shift #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       sa,
   output logic [WIDTH-1:0] sll_res,
   output logic [WIDTH-1:0] srl_res,
   output logic [WIDTH-1:0] sra_res
);

   // sa is 5 bits wide, so shifts of WIDTH or more cannot occur
   always_comb begin
      sll_res = b << sa;
      srl_res = b >> sa;
      sra_res = WIDTH'($signed(b) >>> sa);
   end

endmodule

// Adder/subtractor with signed-overflow detection for ADD and SUB.
module mips_alu_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] diff,
   output logic             sum_ovf,
   output logic             diff_ovf
);

   // Overflow: operands of the relevant sign relation but result sign
   // differs from A. The wrapped value is still returned.
   always_comb begin
      sum      = a + b;
      diff     = a - b;
      sum_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
      diff_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

module mips_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rs_out,
   input  logic [WIDTH-1:0] rt_out,
   input  logic [WIDTH-1:0] imm_ext,
   input  logic [WIDTH-1:0] ins,
   input  logic [3:0]       aluop,
   input  logic             sll_slt,
   input  logic             ALUSrc,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_NOR   = 4'd5;
   localparam logic [3:0] OP_SLL   = 4'd6;
   localparam logic [3:0] OP_SRL   = 4'd7;
   localparam logic [3:0] OP_SRA   = 4'd8;
   localparam logic [3:0] OP_SLT   = 4'd9;
   localparam logic [3:0] OP_SLTU  = 4'd10;
   localparam logic [3:0] OP_LUI   = 4'd11;
   localparam logic [3:0] OP_PASSA = 4'd12;
   localparam logic [3:0] OP_PASSB = 4'd13;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [4:0]       sa;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             sum_ovf;
   logic             diff_ovf;
   logic [WIDTH-1:0] sll_res;
   logic [WIDTH-1:0] srl_res;
   logic [WIDTH-1:0] sra_res;

   logic [WIDTH-1:0] next_result;
   logic             next_zero;
   logic             next_overflow;

   // Operand B from register or immediate; shift amount from shamt or rs
   always_comb begin
      op_a = rs_out;
      op_b = ALUSrc  ? imm_ext    : rt_out;
      sa   = sll_slt ? rs_out[4:0] : ins[10:6];
   end

   mips_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a        (op_a),
      .b        (op_b),
      .sum      (sum),
      .diff     (diff),
      .sum_ovf  (sum_ovf),
      .diff_ovf (diff_ovf)
   );

   mips_alu_shift #(.WIDTH(WIDTH)) u_shift (
      .b       (op_b),
      .sa      (sa),
      .sll_res (sll_res),
      .srl_res (srl_res),
      .sra_res (sra_res)
   );

   // Operation select; reserved encodings yield 0 (and hence zero = 1)
   always_comb begin
      next_result   = '0;
      next_overflow = 1'b0;
      case (aluop)
         OP_ADD: begin
            next_result   = sum;
            next_overflow = sum_ovf;
         end
         OP_SUB: begin
            next_result   = diff;
            next_overflow = diff_ovf;
         end
         OP_AND:   next_result = op_a & op_b;
         OP_OR:    next_result = op_a | op_b;
         OP_XOR:   next_result = op_a ^ op_b;
         OP_NOR:   next_result = ~(op_a | op_b);
         OP_SLL:   next_result = sll_res;
         OP_SRL:   next_result = srl_res;
         OP_SRA:   next_result = sra_res;
         OP_SLT:   next_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU:  next_result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         OP_LUI:   next_result = {op_b[15:0], 16'b0};
         OP_PASSA: next_result = op_a;
         OP_PASSB: next_result = op_b;
         default:  next_result = '0;
      endcase
      next_zero = (next_result == '0);
   end

   // EX/MEM result register; async reset clears all outputs immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         result   <= next_result;
         zero     <= next_zero;
         overflow <= next_overflow;
      end
   end

endmodule

// File: tb/tb_mips_alu.sv
// Directed self-checking bench for mips_alu.
module tb_mips_alu;

   logic        clk;
   logic        reset;
   logic [31:0] rs_out;
   logic [31:0] rt_out;
   logic [31:0] imm_ext;
   logic [31:0] ins;
   logic [3:0]  aluop;
   logic        sll_slt;
   logic        ALUSrc;
   logic [31:0] result;
   logic        zero;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   mips_alu #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .rs_out   (rs_out),
      .rt_out   (rt_out),
      .imm_ext  (imm_ext),
      .ins      (ins),
      .aluop    (aluop),
      .sll_slt  (sll_slt),
      .ALUSrc   (ALUSrc),
      .result   (result),
      .zero     (zero),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge and settle
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] rt, input logic [31:0] imm,
                        input logic src, input logic [31:0] iw, input logic sv);
      aluop = op; rs_out = a; rt_out = rt; imm_ext = imm;
      ALUSrc = src; ins = iw; sll_slt = sv;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(4'd15, 32'hFFFFFFFF, 32'd4, 32'd0, 1'b0, 32'd0, 1'b0);
      #3;
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_result got %h exp %h", result, 32'd0); end
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL rst_zero got %b exp 0", zero); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
      @(posedge clk); #1;
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_hold got %h exp 0", result); end
      @(negedge clk);
      reset = 1'b1;
      cyc();
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL resv_result got %h exp 0", result); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL resv_zero got %b exp 1", zero); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL resv_ovf got %b exp 0", overflow); end
      aluop = 4'd14;
      cyc();
      checks++; if (result !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL resv14 got %h/%b exp 0/1", result, zero); end
   endtask

   task automatic test_add_sub();
      drive(4'd0, 32'hFFFFFFFF, 32'd4, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'h00000003) begin errors++; $display("FAIL add_result got %h exp 00000003", result); end
      checks++; if (overflow !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL add_flags got ovf=%b z=%b exp 0/0", overflow, zero); end
      drive(4'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL add_ovf_result got %h exp 80000000", result); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL add_ovf got %b exp 1", overflow); end
      drive(4'd1, 32'h80000000, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'h7FFFFFFF) begin errors++; $display("FAIL sub_ovf_result got %h exp 7fffffff", result); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sub_ovf got %b exp 1", overflow); end
      drive(4'd1, 32'd10, 32'd3, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'd7 || overflow !== 1'b0) begin errors++; $display("FAIL sub_plain got %h/%b exp 00000007/0", result, overflow); end
      // same bit pattern as an add overflow, but non-arith op must not flag
      drive(4'd12, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'h7FFFFFFF || overflow !== 1'b0) begin errors++; $display("FAIL passa got %h/%b exp 7fffffff/0", result, overflow); end
   endtask

   task automatic test_alusrc();
      drive(4'd0, 32'h00008000, 32'd5, 32'hFFFF8000, 1'b1, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL src_imm got %h/%b exp 0/1", result, zero); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL src_imm_ovf got %b exp 0", overflow); end
      ALUSrc = 1'b0;
      cyc();
      checks++; if (result !== 32'h00008005 || zero !== 1'b0) begin errors++; $display("FAIL src_rt got %h/%b exp 00008005/0", result, zero); end
      drive(4'd13, 32'd0, 32'd5, 32'hFFFF8000, 1'b1, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'hFFFF8000) begin errors++; $display("FAIL passb got %h exp ffff8000", result); end
   endtask

   task automatic test_shifts();
      drive(4'd6, 32'd0, 32'h80000010, 32'd0, 1'b0, 32'h00000100, 1'b0);
      cyc();
      checks++; if (result !== 32'h00000100) begin errors++; $display("FAIL sll got %h exp 00000100", result); end
      aluop = 4'd7;
      cyc();
      checks++; if (result !== 32'h08000001) begin errors++; $display("FAIL srl got %h exp 08000001", result); end
      aluop = 4'd8;
      cyc();
      checks++; if (result !== 32'hF8000001) begin errors++; $display("FAIL sra got %h exp f8000001", result); end
      drive(4'd6, 32'h00000021, 32'h80000010, 32'd0, 1'b0, 32'h00000100, 1'b1);
      cyc();
      checks++; if (result !== 32'h00000020) begin errors++; $display("FAIL sllv got %h exp 00000020", result); end
      drive(4'd8, 32'd0, 32'h80000010, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'h80000010) begin errors++; $display("FAIL sra0 got %h exp 80000010", result); end
      drive(4'd7, 32'h0000001F, 32'h80000010, 32'd0, 1'b0, 32'd0, 1'b1);
      cyc();
      checks++; if (result !== 32'h00000001) begin errors++; $display("FAIL srlv31 got %h exp 00000001", result); end
   endtask

   task automatic test_compare();
      drive(4'd9, 32'hFFFFFFFF, 32'd4, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'd1) begin errors++; $display("FAIL slt got %h exp 00000001", result); end
      aluop = 4'd10;
      cyc();
      checks++; if (result !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL sltu got %h/%b exp 0/1", result, zero); end
      drive(4'd9, 32'd4, 32'd4, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL slt_eq got %h/%b exp 0/1", result, zero); end
      drive(4'd10, 32'd3, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'd1) begin errors++; $display("FAIL sltu_lt got %h exp 00000001", result); end
   endtask

   task automatic test_logic();
      drive(4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'h00F000F0) begin errors++; $display("FAIL and got %h exp 00f000f0", result); end
      aluop = 4'd3;
      cyc();
      checks++; if (result !== 32'hFFF0FFF0) begin errors++; $display("FAIL or got %h exp fff0fff0", result); end
      aluop = 4'd4;
      cyc();
      checks++; if (result !== 32'hFF00FF00) begin errors++; $display("FAIL xor got %h exp ff00ff00", result); end
      aluop = 4'd5;
      cyc();
      checks++; if (result !== 32'h000F000F) begin errors++; $display("FAIL nor got %h exp 000f000f", result); end
      drive(4'd11, 32'd0, 32'd0, 32'h00001234, 1'b1, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'h12340000) begin errors++; $display("FAIL lui got %h exp 12340000", result); end
   endtask

   task automatic test_latency();
      drive(4'd0, 32'd20, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      checks++; if (result !== 32'd25) begin errors++; $display("FAIL lat_add got %h exp 00000019", result); end
      #2;
      aluop = 4'd1;
      #1;
      checks++; if (result !== 32'd25) begin errors++; $display("FAIL lat_mid got %h exp 00000019", result); end
      cyc();
      checks++; if (result !== 32'd15) begin errors++; $display("FAIL lat_sub got %h exp 0000000f", result); end
      cyc();
      checks++; if (result !== 32'd15) begin errors++; $display("FAIL lat_hold got %h exp 0000000f", result); end
   endtask

   task automatic test_reset_midop();
      drive(4'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0);
      cyc();
      #2;
      reset = 1'b0;
      #1;
      checks++; if (result !== 32'd0 || overflow !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL midrst got %h/%b/%b exp 0/0/0", result, zero, overflow); end
      drive(4'd3, 32'h00000011, 32'h00000100, 32'd0, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      cyc();
      checks++; if (result !== 32'h00000111) begin errors++; $display("FAIL midrst_rel got %h exp 00000111", result); end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_alusrc();
      test_shifts();
      test_compare();
      test_logic();
      test_latency();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit integer ALU for the MIPS-style pipelined CPU, located in the EX stage.
- Selects operand B (rt_out or imm_ext) and the shift amount (from `ins` or from rs_out).
- Performs one of 14 operations selected by aluop.
- Registers result, zero and overflow, with one-cycle latency into the EX/MEM boundary.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; shifts use 5-bit amounts.

Ports:
- clk  input  1  clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- rs_out  input  32  operand A (GPR[rs]).
- rt_out  input  32  register operand B (GPR[rt]).
- imm_ext  input  32  sign- or zero-extended immediate, already extended upstream.
- ins  input  32  current instruction word; ins[10:6] is shamt.
- aluop  input  4  operation select.
- sll_slt  input  1  shift-amount source: 0 = ins[10:6] (sll/srl/sra), 1 = rs_out[4:0] (sllv/srlv/srav).
- ALUSrc  input  1  operand B select: 0 = rt_out, 1 = imm_ext.
- result  output  32  registered ALU result.
- zero  output  1  registered flag, 1 when the computed result == 0.
- overflow  output  1  registered signed-overflow flag.

Behaviour:
- Reset is asynchronous and active-low. While reset = 0, result = 0, zero = 0, overflow = 0 immediately.
- All outputs update on the rising clk edge after reset is released. Latency is 1 cycle and there is no handshake. A new operation is accepted every cycle.
- Operands:
  - A = rs_out.
  - B = ALUSrc ? imm_ext : rt_out.
  - sa = sll_slt ? rs_out[4:0] : ins[10:6].
- aluop encoding (next_result):
  - 0 ADD: A+B mod 2^32.
  - 1 SUB: A-B mod 2^32.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOR: ~(A|B).
  - 6 SLL: B << sa.
  - 7 SRL: B >> sa, logical.
  - 8 SRA: B >>> sa, arithmetic; sign bit B[31] replicated.
  - 9 SLT: {31'b0, signed(A) < signed(B)}.
  - 10 SLTU: {31'b0, A < B unsigned}.
  - 11 LUI: {B[15:0], 16'b0}.
  - 12 PASSA: A.
  - 13 PASSB: B.
  - 14, 15: reserved; next_result = 0.
- Shift amount 0 passes B unchanged. sa is always 5 bits, so no shift of 32 or more is possible.
- next_zero = (next_result == 0). This includes reserved ops, which therefore give zero = 1.
- Overflow:
  - ADD: A[31] == B[31] && sum[31] != A[31].
  - SUB: A[31] != B[31] && diff[31] != A[31].
  - All other ops: overflow = 0.
- On overflow the result is still the wrapped value. Suppressing the writeback and raising the exception is the controller's job.
- Inputs are sampled only at the clock edge. Input changes between edges have no effect on the outputs.
- If reset is asserted mid-operation, the in-flight result is discarded and the outputs go to 0. The first edge after release registers the then-current inputs.
- Outputs hold their value indefinitely while the inputs are stable. Each edge simply re-registers the same value.

Test Plan:
- Reset then reserved op:
  - Stimulus: reset = 0, rs_out = 0xFFFFFFFF, rt_out = 4, aluop = 15, ALUSrc = 0, sll_slt = 0.
  - Required: all outputs 0 during reset. After release and one edge: result = 0, zero = 1, overflow = 0.
- ADD and overflow:
  - A = 0xFFFFFFFF, B = rt = 4, aluop = 0: result = 0x00000003, overflow = 0, zero = 0.
  - A = 0x7FFFFFFF, rt = 1: result = 0x80000000, overflow = 1.
  - SUB with A = 0x80000000, rt = 1: result = 0x7FFFFFFF, overflow = 1.
- ALUSrc select:
  - ALUSrc = 1, imm_ext = 0xFFFF8000, rs = 0x00008000, aluop = 0: result = 0, zero = 1.
  - Same inputs with ALUSrc = 0, rt = 5: result = 0x8005.
- Shifts:
  - rt = 0x80000010, ins[10:6] = 4, sll_slt = 0:
    - SLL gives 0x00000100.
    - SRL gives 0x08000001.
    - SRA gives 0xF8000001.
  - sll_slt = 1, rs = 0x00000021 (sa = 1), SLL: result = 0x00000020.
- Compare:
  - A = 0xFFFFFFFF, B = 4: SLT gives 1, SLTU gives 0.
  - A = 4, B = 4: SLT gives 0, zero = 1.
- Logic and LUI:
  - A = 0xF0F0F0F0, B = 0x0FF00FF0:
    - AND gives 0x00F000F0.
    - OR gives 0xFFF0FFF0.
    - XOR gives 0xFF00FF00.
    - NOR gives 0x000F000F.
  - LUI with imm = 0x00001234: result = 0x12340000.
- Latency check: change aluop mid-cycle. result changes only at the next rising edge, exactly one cycle after the inputs are sampled.
